// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed multi-digit seven-segment driver with blank/blink
// Optional anti-ghosting dead time at the start of each dwell: define SEG_SCAN_DEADTIME_EN.
module seg_scan_display #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 6000,
    parameter int BLINK_HALF   = 2_500_000,
    parameter int DEAD_CYCLES  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [DWELL_W-1:0] DEAD_END   = DWELL_W'(DEAD_CYCLES);

`ifdef SEG_SCAN_DEADTIME_EN
    localparam bit DEADTIME_ON = 1'b1;
`else
    localparam bit DEADTIME_ON = 1'b0;
`endif

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan and blink timing state
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               started_q, started_d;

    // Double-buffered display contents
    logic [NUM_DIGITS-1:0][3:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]      pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0]      pend_blink_q, pend_blink_d;
    logic [NUM_DIGITS-1:0][3:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]      act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]      act_blink_q, act_blink_d;

    // Registered pin drive
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_tick_q, frame_tick_d;

    logic dwell_done;
    logic wrap;
    logic blink_done;
    logic dead;
    logic dark;

    always_comb begin
        dwell_done  = (dwell_cnt_q == DWELL_LAST);
        wrap        = dwell_done && (idx_q == LAST_IDX);
        dwell_cnt_d = dwell_done ? '0 : dwell_cnt_q + 1'b1;
        idx_d       = idx_q;
        if (dwell_done) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        blink_done    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d   = blink_done ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_done;
    end

    // pend_*_d already carries a same-edge load, so a commit on that edge bypasses pending
    always_comb begin
        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_blink_d  = pend_blink_q;
        if (load) begin
            pend_digits_d = digits_in;
            pend_blank_d  = blank_in;
            pend_blink_d  = blink_in;
        end

        act_digits_d = act_digits_q;
        act_blank_d  = act_blank_q;
        act_blink_d  = act_blink_q;
        started_d    = started_q;
        if (wrap) begin
            act_digits_d = pend_digits_d;
            act_blank_d  = pend_blank_d;
            act_blink_d  = pend_blink_d;
            started_d    = 1'b1;
        end
    end

    // Pins stay dark until the first commit has put real content in the active buffer
    always_comb begin
        dead = DEADTIME_ON && (dwell_cnt_q < DEAD_END);
        dark = !started_q || dead || act_blank_q[idx_q] ||
               (act_blink_q[idx_q] && blink_phase_q);

        seg_d = dark ? SEG_OFF : hex_decode(act_digits_q[idx_q]);
        an_n_d = '1;
        if (started_q && !dead) begin
            an_n_d = ~(NUM_DIGITS'(1) << idx_q);
        end
        frame_tick_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt_q   <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            started_q     <= 1'b0;
            pend_digits_q <= '0;
            pend_blank_q  <= '1;
            pend_blink_q  <= '0;
            act_digits_q  <= '0;
            act_blank_q   <= '1;
            act_blink_q   <= '0;
            seg_q         <= SEG_OFF;
            an_n_q        <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            dwell_cnt_q   <= dwell_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            started_q     <= started_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_blink_q  <= pend_blink_d;
            act_digits_q  <= act_digits_d;
            act_blank_q   <= act_blank_d;
            act_blink_q   <= act_blink_d;
            seg_q         <= seg_d;
            an_n_q        <= an_n_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display (honours SEG_SCAN_DEADTIME_EN)
module tb_seg_scan_display;

    localparam int ND = 2;
    localparam int DW = 4;
    localparam int BH = 8;
    localparam int DC = 1;
    localparam int FRAME = DW * ND;

`ifdef SEG_SCAN_DEADTIME_EN
    localparam bit DT_ON = 1'b1;
`else
    localparam bit DT_ON = 1'b0;
`endif

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [4*ND-1:0] digits_in = '0;
    logic [ND-1:0]   blank_in = '0;
    logic [ND-1:0]   blink_in = '0;
    logic [6:0]      seg;
    logic [ND-1:0]   an_n;
    logic            frame_tick;

    seg_scan_display #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DW),
        .BLINK_HALF  (BH),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .digits_in (digits_in),
        .blank_in  (blank_in),
        .blink_in  (blink_in),
        .seg       (seg),
        .an_n      (an_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]    seg;
        logic [ND-1:0] an;
        logic          ft;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference state: cycles since reset plus the two buffers as plain arrays
    int       t = 0;
    bit       started = 1'b0;
    logic [3:0] pend_dig [ND];
    logic [3:0] act_dig  [ND];
    bit         pend_blk [ND];
    bit         act_blk  [ND];
    bit         pend_bln [ND];
    bit         act_bln  [ND];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        int   idx;
        int   dwell;
        bit   phase;
        bit   dead;
        if (reset) begin
            e.seg = 7'h7F;
            e.an  = '1;
            e.ft  = 1'b0;
            t = 0;
            started = 1'b0;
            for (int i = 0; i < ND; i++) begin
                pend_dig[i] = 4'h0; act_dig[i] = 4'h0;
                pend_blk[i] = 1'b1; act_blk[i] = 1'b1;
                pend_bln[i] = 1'b0; act_bln[i] = 1'b0;
            end
        end else begin
            idx   = (t / DW) % ND;
            dwell = t % DW;
            phase = ((t / BH) % 2) == 1;
            dead  = DT_ON && (dwell < DC);
            e.an = '1;
            if (started && !dead) e.an[idx] = 1'b0;
            if (!started || dead || act_blk[idx] || (act_bln[idx] && phase))
                e.seg = 7'h7F;
            else
                e.seg = DEC[act_dig[idx]];
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    pend_dig[i] = digits_in[4*i +: 4];
                    pend_blk[i] = blank_in[i];
                    pend_bln[i] = blink_in[i];
                end
            end
            t++;
            e.ft = (t % FRAME) == 0;
            if (e.ft) begin
                act_dig = pend_dig;
                act_blk = pend_blk;
                act_bln = pend_bln;
                started = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit ld, input logic [4*ND-1:0] d,
                        input logic [ND-1:0] bk, input logic [ND-1:0] bl);
        reset = r;
        load = ld;
        digits_in = d;
        blank_in = bk;
        blink_in = bl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, (4*ND)'($urandom), ND'($urandom), ND'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg", 32'(seg), 32'(e.seg));
                check("an_n", 32'(an_n), 32'(e.an));
                check("frame_tick", 32'(frame_tick), 32'(e.ft));
            end
        end
    end

    initial begin : driver
        bit r;
        bit ld;
        repeat (3) step(1'b1, 1'b0, '0, '0, '0);
        repeat (2) idle();
        step(1'b0, 1'b1, 8'h1A, 2'b00, 2'b00);
        repeat (12) idle();
        step(1'b0, 1'b1, 8'h1A, 2'b10, 2'b00);
        repeat (16) idle();
        step(1'b0, 1'b1, 8'h1A, 2'b00, 2'b01);
        repeat (40) idle();
        while (((t + 1) % FRAME) != 0) idle();
        step(1'b0, 1'b1, 8'h80, 2'b00, 2'b00);
        repeat (10) idle();
        while (((t / DW) % ND) != 1) idle();
        idle();
        step(1'b1, 1'b0, '0, '0, '0);
        repeat (12) idle();
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 5) == 0);
            if (ld && ($urandom_range(0, 1) == 0)) begin
                while (((t + 1) % FRAME) != 0) idle();
            end
            step(r, ld, (4*ND)'($urandom), ND'($urandom), ND'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multi-digit, time-multiplexed seven-segment driver, successor to the single-digit decoder plus blink LED.
- Holds NUM_DIGITS hex nibbles in a double buffer.
- Scans one digit at a time with active-low segment and anode drive.
- Adds per-digit blanking and per-digit blinking from an internal blink divider.
- Sits between the switch/counter logic and the board display pins.

Parameters:
NUM_DIGITS, 2, number of digits scanned (1..8).
DWELL_CYCLES, 6000, clk cycles each digit stays selected (≥2); 6000 @12 MHz = 2 kHz per digit.
BLINK_HALF, 2_500_000, clk cycles per blink half-period; blink phase toggles at this interval.
DEAD_CYCLES, 64, blanking cycles at the start of each dwell (used only with DEADTIME_EN); must be < DWELL_CYCLES.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
load  in  1  capture strobe for digits_in/blank_in/blink_in into the pending buffer.
digits_in  in  4*NUM_DIGITS  nibble k = digits_in[4k+3:4k] is the value for digit k.
blank_in  in  NUM_DIGITS  bit k=1: digit k dark.
blink_in  in  NUM_DIGITS  bit k=1: digit k blinks.
seg  out  7  active-low segments, seg[6:0]={g,f,e,d,c,b,a}.
an_n  out  NUM_DIGITS  active-low digit select; at most one bit low.
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (synchronous, active-high):
  - dwell_cnt=0, idx=0, blink_cnt=0, blink_phase=0.
  - pending and active digits = 0; pending and active blank = all ones; blink = 0.
  - Outputs: seg=7'h7F, an_n=all ones, frame_tick=0.
  - Reset asserted mid-scan aborts the scan and forces these values on the same edge; scan restarts at digit 0 with a full dwell.
- Load:
  - load=1 on an edge copies all three inputs into pending.
  - Back-to-back loads: last one wins.
  - Pending is not displayed until commit.
- Scan:
  - dwell_cnt counts 0..DWELL_CYCLES-1.
  - At terminal count: dwell_cnt→0 and idx→idx+1, wrapping NUM_DIGITS-1→0.
- Commit (on the edge where idx wraps to 0):
  - active ← pending.
  - If load=1 on that same edge, active ← the input values directly (bypass) and pending ← the same values.
  - frame_tick=1 for exactly the cycle after that edge.
- Blink:
  - blink_cnt counts 0..BLINK_HALF-1; at terminal count it wraps to 0 and blink_phase toggles.
  - Blink runs free, independent of scan and load.
- Output pipeline (one registered stage):
  - an_n = ~(1<<idx).
  - seg = 7'h7F if active_blank[idx], or if active_blink[idx] & blink_phase.
  - Otherwise seg = decode(active_digit[idx]).
  - Outputs reflect idx/active state one cycle after the edge that changed them.
- Decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- NUM_DIGITS=1: idx constant 0; frame_tick pulses once every DWELL_CYCLES.

Optional Feature:
SEG_SCAN_DEADTIME_EN.
- Defined: while dwell_cnt < DEAD_CYCLES, registered an_n=all ones and seg=7'h7F (anti-ghosting). Scan, commit and frame_tick timing are unchanged.
- Undefined: no dead time; the selected digit drives for the full dwell. DEAD_CYCLES is ignored.

Test Plan:
1. Reset behaviour (NUM_DIGITS=2, DWELL_CYCLES=4, BLINK_HALF=8): hold reset 3 cycles, release → seg=7F, an_n=11 until first commit; first frame_tick 8 cycles after release.
2. Load and commit: load digits_in=0x1A, blank_in=00, blink_in=00 mid-frame → old (dark) frame completes; after frame_tick, digit0 an_n=10 with seg=08, then digit1 an_n=01 with seg=79, each for 4 cycles.
3. Blank: load blank_in=10 → after commit, digit1 slot shows an_n=01 with seg=7F; digit0 still shows 08.
4. Blink: load blink_in=01 → digit0 shows 08 for 8 cycles while blink_phase=0 and 7F for 8 cycles while blink_phase=1; digit1 unaffected.
5. Simultaneous events: assert load with 0x80 on the exact wrap edge → next frame shows digit0 seg=40 and digit1 seg=00 (bypass commit); pulse reset during digit1 dwell → outputs at reset values on the next cycle.
6. With SEG_SCAN_DEADTIME_EN and DEAD_CYCLES=1 → first cycle of each dwell has an_n=11 and seg=7F; remaining 3 cycles are normal.
